rsa_modmul: RTL

//  Datapath responder for rsa_core_ctrl: computes dinx = (x * m) mod n.

---
 rtl/rsa_pkg.sv | 25 ++
 rtl/rsa_modsub_step.sv | 39 +++
 rtl/rsa_modmul.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA modular-multiply datapath.
//  - state_t   : sequencer states (IDLE / RED / MUL / RSP)
//  - ONE       : unit step for the bit counter
//  - ERR_BIT   : fill bit for the n==0 error result (all ones)
//  - acc_width : accumulator width, W+2 bits, enough for 2*acc + addend < 3n
// ---------------------------------------------------------------------------
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RED  = 2'd1,
    MUL  = 2'd2,
    RSP  = 2'd3
  } state_t;

  localparam int   ONE     = 1;
  localparam logic ERR_BIT = 1'b1;

  function automatic int acc_width(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/rsa_modsub_step.sv
// ---------------------------------------------------------------------------
// rsa_modsub_step
// One interleaved modular step: res = (2*acc + addend) reduced by up to SUBS
// conditional subtractions of n. With acc < n and addend < n, SUBS=2 keeps
// the result below n; SUBS=1 suffices when addend is a single bit.
// Ports:
//  acc    in  W+2  running accumulator (always < n)
//  addend in  W+2  value added after the doubling
//  n      in  W    modulus
//  res    out W+2  reduced result
// ---------------------------------------------------------------------------
module rsa_modsub_step
  import rsa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SUBS       = 1
) (
  input  logic [acc_width(DATA_WIDTH)-1:0] acc,
  input  logic [acc_width(DATA_WIDTH)-1:0] addend,
  input  logic [DATA_WIDTH-1:0]            n,
  output logic [acc_width(DATA_WIDTH)-1:0] res
);

  localparam int AW = acc_width(DATA_WIDTH);

  logic [AW-1:0] n_ext;
  logic [AW-1:0] s;

  assign n_ext = {{(AW-DATA_WIDTH){1'b0}}, n};

  always_comb begin
    s = (acc << 1) + addend;
    for (int i = 0; i < SUBS; i++) begin
      if (s >= n_ext) s = s - n_ext;
    end
    res = s;
  end

endmodule

// File: rtl/rsa_modmul.sv
// ---------------------------------------------------------------------------
// rsa_modmul
// Sequential modular multiplier answering rsa_core_ctrl: dinx = (x*m) mod n.
// Phase RED reduces m mod n one bit per cycle (MSB first), phase MUL does an
// interleaved shift-add multiply of x by that residue, one bit per cycle.
// Ports:
//  ctrl_clk    in   1  clock
//  ctrl_rst    in   1  asynchronous reset, active low
//  ctrl_start  in   1  request; operands captured on the edge it is sampled
//  ctrl_doutx  in   W  multiplicand x
//  ctrl_m      in   W  multiplier m (may exceed n)
//  ctrl_n      in   W  modulus n (0 yields all-ones error result)
//  ctrl_loadx  out  1  one-cycle result strobe
//  ctrl_dinx   out  W  result, held until the next strobe
//  mm_busy     out  1  operation in progress
// ---------------------------------------------------------------------------
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  ctrl_clk,
  input  logic                  ctrl_rst,
  input  logic                  ctrl_start,
  input  logic [DATA_WIDTH-1:0] ctrl_doutx,
  input  logic [DATA_WIDTH-1:0] ctrl_m,
  input  logic [DATA_WIDTH-1:0] ctrl_n,
  output logic                  ctrl_loadx,
  output logic [DATA_WIDTH-1:0] ctrl_dinx,
  output logic                  mm_busy
);

  localparam int            AW      = acc_width(DATA_WIDTH);
  localparam int            CW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DATA_WIDTH - 1);

  state_t state_q, state_n;
  logic   loadx_n;

  logic [DATA_WIDTH-1:0] x_q, m_q, n_q;
  logic [AW-1:0]         r_q, p_q;
  logic [CW-1:0]         cnt_q;

  logic [AW-1:0] red_addend, mul_addend;
  logic [AW-1:0] r_step, p_step;

  assign red_addend = {{(AW-1){1'b0}}, m_q[cnt_q]};
  assign mul_addend = x_q[cnt_q] ? r_q : '0;

  rsa_modsub_step #(.DATA_WIDTH(DATA_WIDTH), .SUBS(1)) u_red (
    .acc    (r_q),
    .addend (red_addend),
    .n      (n_q),
    .res    (r_step)
  );

  rsa_modsub_step #(.DATA_WIDTH(DATA_WIDTH), .SUBS(2)) u_mul (
    .acc    (p_q),
    .addend (mul_addend),
    .n      (n_q),
    .res    (p_step)
  );

  always_ff @(posedge ctrl_clk or negedge ctrl_rst) begin
    if (!ctrl_rst) state_q <= IDLE;
    else           state_q <= state_n;
  end

  // A new start overrides whatever is running; RSP still strobes its result.
  always_comb begin
    state_n = state_q;
    loadx_n = 1'b0;
    case (state_q)
      IDLE: state_n = IDLE;
      RED:  if (cnt_q == '0) state_n = MUL;
      MUL:  if (cnt_q == '0) state_n = RSP;
      RSP: begin
        loadx_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (ctrl_start) state_n = (ctrl_n == '0) ? RSP : RED;
  end

  // Operands are used only from the capture registers; the controller
  // reuses its live buses while it waits.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst) begin
    if (!ctrl_rst) begin
      x_q   <= '0;
      m_q   <= '0;
      n_q   <= '0;
      r_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else if (ctrl_start) begin
      x_q   <= ctrl_doutx;
      m_q   <= ctrl_m;
      n_q   <= ctrl_n;
      r_q   <= '0;
      cnt_q <= CNT_TOP;
      p_q   <= (ctrl_n == '0) ? {{(AW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{ERR_BIT}}} : '0;
    end else begin
      case (state_q)
        RED: begin
          r_q <= r_step;
          if (cnt_q == '0) begin
            p_q   <= '0;
            cnt_q <= CNT_TOP;
          end else begin
            cnt_q <= cnt_q - CW'(ONE);
          end
        end
        MUL: begin
          p_q <= p_step;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(ONE);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_rst) begin
    if (!ctrl_rst) begin
      ctrl_loadx <= 1'b0;
      ctrl_dinx  <= '0;
      mm_busy    <= 1'b0;
    end else begin
      ctrl_loadx <= loadx_n;
      if (loadx_n) ctrl_dinx <= p_q[DATA_WIDTH-1:0];
      mm_busy    <= (state_n != IDLE);
    end
  end

endmodule
